// File: rtl/bus_ctl_pkg.sv
// Shared op codes, FSM states and command validation for the bus transfer controller.
package bus_ctl_pkg;

    typedef enum logic [1:0] {
        OP_MOV  = 2'b00,
        OP_PAIR = 2'b01,
        OP_CLR  = 2'b10,
        OP_RSVD = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER_LO,
        ST_XFER_HI,
        ST_DONE
    } state_e;

    localparam int unsigned SEL_NONE = 0;

    // A PAIR touches code+1 as well, so both ends of the pair must exist.
    function automatic logic cmd_is_legal(input logic [1:0]  op,
                                          input int unsigned src,
                                          input int unsigned dst,
                                          input int unsigned num_regs);
        logic ok;
        ok = 1'b1;
        if (src > num_regs || dst > num_regs) ok = 1'b0;
        if (op == OP_RSVD) ok = 1'b0;
        if (op == OP_PAIR && src != SEL_NONE && src + 1 > num_regs) ok = 1'b0;
        if (op == OP_PAIR && dst != SEL_NONE && dst + 1 > num_regs) ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/bus_transfer_controller_if.sv
// Command handshake and bus signals of the bus transfer controller.
interface bus_transfer_controller_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
);
    localparam int SEL_W = $clog2(NUM_REGS + 1);

    logic                         i_cmd_valid;
    logic                         o_cmd_ready;
    logic [1:0]                   i_cmd_op;
    logic [SEL_W-1:0]             i_cmd_src;
    logic [SEL_W-1:0]             i_cmd_dst;
    logic [DATA_W-1:0]            i_bus_in;
    logic [SEL_W-1:0]             i_left_sel;
    logic [SEL_W-1:0]             i_right_sel;
    logic [DATA_W-1:0]            o_b_main;
    logic [DATA_W-1:0]            o_b_left;
    logic [DATA_W-1:0]            o_b_right;
    logic [NUM_REGS*DATA_W-1:0]   o_reg_data;
    logic                         o_done;
    logic                         o_err;

    modport master (
        output i_cmd_valid, i_cmd_op, i_cmd_src, i_cmd_dst, i_bus_in,
               i_left_sel, i_right_sel,
        input  o_cmd_ready, o_b_main, o_b_left, o_b_right, o_reg_data,
               o_done, o_err
    );

    modport slave (
        input  i_cmd_valid, i_cmd_op, i_cmd_src, i_cmd_dst, i_bus_in,
               i_left_sel, i_right_sel,
        output o_cmd_ready, o_b_main, o_b_left, o_b_right, o_reg_data,
               o_done, o_err
    );

endinterface

// File: rtl/bus_reg_file.sv
// General register file: one write port, three combinational read ports, 1-based codes.
module bus_reg_file #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [SEL_W-1:0]           wr_idx,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [SEL_W-1:0]           rd_a_idx,
    output logic [DATA_W-1:0]          rd_a_data,
    input  logic [SEL_W-1:0]           rd_b_idx,
    output logic [DATA_W-1:0]          rd_b_data,
    input  logic [SEL_W-1:0]           rd_c_idx,
    output logic [DATA_W-1:0]          rd_c_data,
    output logic [NUM_REGS*DATA_W-1:0] reg_flat
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (wr_en && 32'(wr_idx) == i + 1) regs_d[i] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Code 0 and codes beyond NUM_REGS read as zero.
    always_comb begin
        rd_a_data = '0;
        rd_b_data = '0;
        rd_c_data = '0;
        reg_flat  = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(rd_a_idx) == i + 1) rd_a_data = regs_q[i];
            if (32'(rd_b_idx) == i + 1) rd_b_data = regs_q[i];
            if (32'(rd_c_idx) == i + 1) rd_c_data = regs_q[i];
            reg_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

endmodule

// File: rtl/bus_transfer_controller.sv
// Command FSM moving bytes between i_bus_in and the register file over the main bus.
module bus_transfer_controller
    import bus_ctl_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bus_transfer_controller_if.slave bus
);

    localparam int SEL_W = $clog2(NUM_REGS + 1);

    state_e           state_q, state_d;
    cmd_op_e          op_q, op_d;
    logic [SEL_W-1:0] src_q, src_d;
    logic [SEL_W-1:0] dst_q, dst_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [SEL_W-1:0]  beat_src, beat_dst;
    logic [DATA_W-1:0] rd_main_data, main_val, wr_data;
    logic              in_beat, wr_en, accept;

    assign in_beat = (state_q == ST_XFER_LO) || (state_q == ST_XFER_HI);
    assign accept  = bus.i_cmd_valid && bus.o_cmd_ready;

    // HI beat of a PAIR uses code+1, except code 0 which stays on the external bus / discard.
    always_comb begin
        beat_src = src_q;
        beat_dst = dst_q;
        if (state_q == ST_XFER_HI) begin
            if (src_q != SEL_W'(SEL_NONE)) beat_src = src_q + SEL_W'(1);
            if (dst_q != SEL_W'(SEL_NONE)) beat_dst = dst_q + SEL_W'(1);
        end
    end

    assign main_val = (beat_src == SEL_W'(SEL_NONE)) ? bus.i_bus_in : rd_main_data;
    assign wr_data  = (op_q == OP_CLR) ? '0 : main_val;
    assign wr_en    = in_beat && (beat_dst != SEL_W'(SEL_NONE));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d  = cmd_op_e'(bus.i_cmd_op);
                    src_d = bus.i_cmd_src;
                    dst_d = bus.i_cmd_dst;
                    if (cmd_is_legal(bus.i_cmd_op, 32'(bus.i_cmd_src),
                                     32'(bus.i_cmd_dst), NUM_REGS)) begin
                        state_d = ST_XFER_LO;
                    end else begin
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_XFER_LO: begin
                if (op_q == OP_PAIR) begin
                    state_d = ST_XFER_HI;
                end else begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_XFER_HI: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MOV;
            src_q   <= '0;
            dst_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    bus_reg_file #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_reg_file (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_idx    (beat_dst),
        .wr_data   (wr_data),
        .rd_a_idx  (beat_src),
        .rd_a_data (rd_main_data),
        .rd_b_idx  (bus.i_left_sel),
        .rd_b_data (bus.o_b_left),
        .rd_c_idx  (bus.i_right_sel),
        .rd_c_data (bus.o_b_right),
        .reg_flat  (bus.o_reg_data)
    );

    assign bus.o_cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign bus.o_b_main    = in_beat ? wr_data : bus.i_bus_in;
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

endmodule

// File: tb/tb_bus_transfer_controller.sv
// Randomized self-checking bench for bus_transfer_controller against a register-array model.
module tb_bus_transfer_controller;

    localparam int DW = 8;
    localparam int NR = 4;
    localparam int SW = $clog2(NR + 1);

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chained = 1'b0;

    logic [DW-1:0] mreg [0:7];

    always #5 clk = ~clk;

    bus_transfer_controller_if #(.DATA_W(DW), .NUM_REGS(NR)) bif ();

    bus_transfer_controller #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input int code);
        return (code >= 1 && code <= NR) ? mreg[code] : '0;
    endfunction

    function automatic logic [NR*DW-1:0] m_flat();
        logic [NR*DW-1:0] f;
        f = '0;
        for (int r = 1; r <= NR; r++) f[(r-1)*DW +: DW] = mreg[r];
        return f;
    endfunction

    function automatic bit m_legal(input int op, input int src, input int dst);
        if (src > NR || dst > NR) return 0;
        if (op == 3) return 0;
        if (op == 1 && src != 0 && src + 1 > NR) return 0;
        if (op == 1 && dst != 0 && dst + 1 > NR) return 0;
        return 1;
    endfunction

    function automatic void m_clear();
        for (int r = 0; r < 8; r++) mreg[r] = '0;
    endfunction

    task automatic settle_and_check(input string tag);
        int ls, rs;
        ls = $urandom_range(0, 7);
        rs = $urandom_range(0, 7);
        bif.i_left_sel  = SW'(ls);
        bif.i_right_sel = SW'(rs);
        #1;
        check({tag, "_regs"},  bif.o_reg_data, m_flat());
        check({tag, "_left"},  bif.o_b_left,   m_read(ls));
        check({tag, "_right"}, bif.o_b_right,  m_read(rs));
    endtask

    // Drives one command and checks every cycle through to IDLE (or to DONE when keep is set).
    task automatic run_cmd(input int op, input int src, input int dst,
                           input logic [DW-1:0] lo, input logic [DW-1:0] hi, input bit keep);
        bit            legal;
        int            waits, hs, hd;
        logic [DW-1:0] v;
        legal = m_legal(op, src, dst);
        bif.i_cmd_valid = 1'b1;
        bif.i_cmd_op    = 2'(op);
        bif.i_cmd_src   = SW'(src);
        bif.i_cmd_dst   = SW'(dst);
        bif.i_bus_in    = lo;
        #1;
        waits = 0;
        while (!bif.o_cmd_ready && waits < 4) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check("accept_wait", waits, chained ? 1 : 0);
        if (!bif.o_cmd_ready) begin
            bif.i_cmd_valid = 1'b0;
            chained = 1'b0;
            return;
        end
        @(negedge clk);
        if (!keep) bif.i_cmd_valid = 1'b0;
        bif.i_cmd_op  = 2'($urandom_range(0, 3));
        bif.i_cmd_src = SW'($urandom_range(0, 7));
        bif.i_cmd_dst = SW'($urandom_range(0, 7));
        settle_and_check("e0");
        if (!legal) begin
            check("err_pulse", bif.o_err, 1'b1);
            check("err_nodone", bif.o_done, 1'b0);
            check("err_ready", bif.o_cmd_ready, 1'b0);
            check("err_main", bif.o_b_main, bif.i_bus_in);
            if (!keep) begin
                @(negedge clk);
                settle_and_check("err_e1");
                check("err_clear", bif.o_err, 1'b0);
                check("err_ready_back", bif.o_cmd_ready, 1'b1);
            end
            chained = keep;
            return;
        end
        v = (op == 2) ? '0 : ((src == 0) ? lo : mreg[src]);
        check("lo_main", bif.o_b_main, v);
        check("lo_ready", bif.o_cmd_ready, 1'b0);
        check("lo_done", bif.o_done, 1'b0);
        if (dst != 0) mreg[dst] = v;
        if (op == 1) begin
            @(negedge clk);
            bif.i_bus_in = hi;
            settle_and_check("hi");
            hs = (src == 0) ? 0 : src + 1;
            hd = (dst == 0) ? 0 : dst + 1;
            v  = (hs == 0) ? hi : mreg[hs];
            check("hi_main", bif.o_b_main, v);
            check("hi_done", bif.o_done, 1'b0);
            if (hd != 0) mreg[hd] = v;
        end
        @(negedge clk);
        settle_and_check("done");
        check("done_pulse", bif.o_done, 1'b1);
        check("done_noerr", bif.o_err, 1'b0);
        check("done_ready", bif.o_cmd_ready, 1'b0);
        check("done_main", bif.o_b_main, bif.i_bus_in);
        if (!keep) begin
            @(negedge clk);
            settle_and_check("idle");
            check("done_clear", bif.o_done, 1'b0);
            check("ready_back", bif.o_cmd_ready, 1'b1);
        end
        chained = keep;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, src, dst;
        bit keep;
        m_clear();
        rst_n           = 1'b0;
        bif.i_cmd_valid = 1'b0;
        bif.i_cmd_op    = '0;
        bif.i_cmd_src   = '0;
        bif.i_cmd_dst   = '0;
        bif.i_bus_in    = 8'h5A;
        bif.i_left_sel  = '0;
        bif.i_right_sel = '0;
        #3;
        settle_and_check("rst");
        check("rst_ready", bif.o_cmd_ready, 1'b0);
        check("rst_done", bif.o_done, 1'b0);
        check("rst_err", bif.o_err, 1'b0);
        check("rst_main", bif.o_b_main, 8'h5A);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", bif.o_cmd_ready, 1'b1);

        run_cmd(0, 0, 2, 8'hA5, 8'h00, 1'b0);
        run_cmd(0, 2, 3, 8'h00, 8'h00, 1'b0);
        bif.i_left_sel  = SW'(3);
        bif.i_right_sel = SW'(2);
        #1;
        check("left_reg3", bif.o_b_left, 8'hA5);
        check("right_reg2", bif.o_b_right, 8'hA5);

        run_cmd(0, 0, 1, 8'h11, 8'h00, 1'b0);
        run_cmd(0, 0, 2, 8'h22, 8'h00, 1'b0);
        run_cmd(1, 1, 2, 8'h00, 8'h00, 1'b0);
        check("pair_overlap_reg3", mreg[3], 8'h11);

        run_cmd(1, 0, 4, 8'h99, 8'h98, 1'b0);
        run_cmd(0, 0, 5, 8'h99, 8'h00, 1'b0);
        run_cmd(3, 1, 1, 8'h99, 8'h00, 1'b0);

        run_cmd(2, 0, 1, 8'h00, 8'h00, 1'b1);
        run_cmd(0, 0, 1, 8'h3C, 8'h00, 1'b0);

        // Abort a PAIR in its HI beat.
        bif.i_cmd_valid = 1'b1;
        bif.i_cmd_op    = 2'd1;
        bif.i_cmd_src   = SW'(1);
        bif.i_cmd_dst   = SW'(2);
        bif.i_bus_in    = 8'h42;
        @(negedge clk);
        bif.i_cmd_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        m_clear();
        settle_and_check("rst_mid");
        check("rst_mid_ready", bif.o_cmd_ready, 1'b0);
        check("rst_mid_done", bif.o_done, 1'b0);
        check("rst_mid_err", bif.o_err, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            check("rst_hold_done", bif.o_done, 1'b0);
            check("rst_hold_err", bif.o_err, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        chained = 1'b0;
        run_cmd(0, 0, 3, 8'h77, 8'h00, 1'b0);

        for (int n = 0; n < 80; n++) begin
            op   = $urandom_range(0, 3);
            src  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            dst  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
            keep = (n != 79) && ($urandom_range(0, 3) == 0);
            run_cmd(op, src, dst, 8'($urandom), 8'($urandom), keep);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_transfer_controller.md
# bus_transfer_controller

Parametrised, clocked successor to the bus-control board: owns a file of NUM_REGS general registers and moves data between them and the external input over the main bus, under a valid/ready command handshake. Supports single-byte moves, two-beat register-pair moves and clears, and reports illegal commands. Left/right buses are driven combinationally from per-bus selectors for downstream ALU operand staging.

## Interface
- DATA_W, 8, width of every register and 8-bit bus
- NUM_REGS, 4, general registers, legal range 1..15
- SEL_W (localparam), $clog2(NUM_REGS+1), selector width; code 0 = external/none, codes 1..NUM_REGS = register
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_cmd_valid  in  1  command offered
- o_cmd_ready  out  1  high only in IDLE with rst_n high
- i_cmd_op  in  2  00 MOV, 01 PAIR, 10 CLR, 11 reserved
- i_cmd_src  in  SEL_W  source code (0 = i_bus_in)
- i_cmd_dst  in  SEL_W  destination code (0 = discard)
- i_bus_in  in  DATA_W  external data
- i_left_sel, i_right_sel  in  SEL_W  left/right bus selectors
- o_b_main, o_b_left, o_b_right  out  DATA_W  bus values
- o_reg_data  out  NUM_REGS*DATA_W  register r at [(r-1)*DATA_W +: DATA_W]
- o_done  out  1  one-cycle pulse, command completed
- o_err  out  1  one-cycle pulse, command rejected

## Operation
- States: IDLE, XFER_LO, XFER_HI, DONE.
- Accept on rising edge with i_cmd_valid && o_cmd_ready; op/src/dst latched; later input changes ignored.
- Validation at accept: src or dst > NUM_REGS, op 11, PAIR with src≠0 and src+1 > NUM_REGS, PAIR with dst≠0 and dst+1 > NUM_REGS -> DONE with o_err=1, o_done=0, no write.
- MOV: IDLE -> XFER_LO -> DONE; o_b_main = source; dst written at end of XFER_LO.
- CLR: as MOV but write value 0, o_b_main = 0 during XFER_LO; src ignored.
- PAIR: IDLE -> XFER_LO -> XFER_HI -> DONE; LO beat moves src -> dst, HI beat moves src+1 -> dst+1; src 0 samples i_bus_in in each beat. Overlap (dst = src+1) is defined: HI beat reads the value written by LO.
- dst 0: bus still driven, nothing written, o_done still pulses.
- DONE: o_done (or o_err) high for one cycle, then IDLE.
- o_b_main in IDLE/DONE = i_bus_in.
- o_b_left/right: combinational register value for codes 1..NUM_REGS; i_bus_in for 0 is not permitted — code 0 or out-of-range drives 0. Reflect register state after each write edge.

## Timing
- Reset (async assert, sync-safe release): all registers 0, state IDLE, o_done=o_err=0, o_cmd_ready=0 while rst_n low, o_b_main = i_bus_in, left/right = selected (0) values.
- MOV/CLR: accept edge E0, write at E1, o_done high E1..E2, o_cmd_ready high from E2. Error: o_err high E0..E1, ready from E1.
- PAIR: writes at E1 and E2, o_done E2..E3, ready from E3.
- Back-to-back: valid held high gets next accept at the first edge with ready high; no bubble beyond DONE.
- Reset mid-command: immediate abort to IDLE, all registers 0, no o_done/o_err.

## Structure
- Shared package bus_ctl_pkg: op codes, state encoding, SEL_NONE = 0 constant.
- Sub-module bus_reg_file: NUM_REGS x DATA_W, one write port (enable, 1-based index, data), three combinational read ports, async active-low clear. Controller holds FSM, validation and bus muxing.

## Test plan
- Reset, then MOV src 0 (i_bus_in=0xA5) -> dst 2 -> reg2=0xA5 at E1, o_done at E1, ready at E2; other regs 0.
- MOV 2 -> 3, left_sel 3, right_sel 2 -> after E1 o_b_left=o_b_right=0xA5.
- Regs 1=0x11, 2=0x22; PAIR 1 -> 2 -> reg2=0x11 at E1, reg3=0x11 at E2 (overlap rule), o_done E2.
- NUM_REGS=4: PAIR dst 4, MOV dst 5, op 11 -> each gives one-cycle o_err, no register change, ready next cycle.
- CLR dst 1 with valid held high and queued MOV 0 -> 1 (i_bus_in=0x3C) -> reg1=0 then 0x3C, second accept exactly at the edge ready rises.
- rst_n low during PAIR XFER_HI -> all regs 0, IDLE immediately, no o_done; commands accepted after release.
